// File: rtl/msrv32_pkg.sv
// Shared types and constants for the msrv32 trap path: FSM states, mcause codes
// and next-PC source encodings.
package msrv32_pkg;

  typedef enum logic [1:0] {
    STATE_RESET       = 2'b00,
    STATE_OPERATING   = 2'b01,
    STATE_TRAP_TAKEN  = 2'b10,
    STATE_TRAP_RETURN = 2'b11
  } trap_state_t;

  localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0] CAUSE_BREAK          = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;
  localparam logic [3:0] CAUSE_MSI            = 4'd3;
  localparam logic [3:0] CAUSE_MTI            = 4'd7;
  localparam logic [3:0] CAUSE_MEI            = 4'd11;

  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_NEXT = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_EPC  = 2'b11;

endpackage

// File: rtl/msrv32_trap_priority_encoder.sv
// Combinational trap detector: resolves simultaneous exception flags and
// enabled pending interrupts into one cause; exceptions always win.
module msrv32_trap_priority_encoder
  import msrv32_pkg::*;
(
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       ecall_in,
  input  logic       ebreak_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic       exc,
  output logic       irq,
  output logic [3:0] cause,
  output logic       i_or_e
);

  logic ext_irq;
  logic sw_irq;
  logic tmr_irq;

  assign ext_irq = meie_in & meip_in;
  assign sw_irq  = msie_in & msip_in;
  assign tmr_irq = mtie_in & mtip_in;

  assign exc = illegal_instr_in | misaligned_instr_in | misaligned_load_in |
               misaligned_store_in | ecall_in | ebreak_in;
  assign irq = mie_in & (ext_irq | sw_irq | tmr_irq);

  // i_or_e only marks an interrupt when no exception competes in the same cycle
  assign i_or_e = ~exc & irq;

  always_comb begin
    cause = CAUSE_INSTR_MISALIGN;
    if (exc) begin
      if (ebreak_in)                cause = CAUSE_BREAK;
      else if (misaligned_instr_in) cause = CAUSE_INSTR_MISALIGN;
      else if (illegal_instr_in)    cause = CAUSE_ILLEGAL;
      else if (ecall_in)            cause = CAUSE_ECALL_M;
      else if (misaligned_store_in) cause = CAUSE_STORE_MISALIGN;
      else                          cause = CAUSE_LOAD_MISALIGN;
    end else if (irq) begin
      if (ext_irq)     cause = CAUSE_MEI;
      else if (sw_irq) cause = CAUSE_MSI;
      else             cause = CAUSE_MTI;
    end
  end

endmodule

// File: rtl/msrv32_trap_controller.sv
// Machine-mode trap sequencer: four-state FSM that drives the CSR file trap
// controls, next-PC source select and pipeline flush.
module msrv32_trap_controller
  import msrv32_pkg::*;
(
  input  logic       clock,
  input  logic       rst_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       ecall_in,
  input  logic       ebreak_in,
  input  logic       mret_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic       i_or_e_out,
  output logic [3:0] cause_out,
  output logic       set_cause_out,
  output logic       set_epc_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       misaligned_exception_out,
  output logic       instret_inc_out,
  output logic [1:0] pc_src_out,
  output logic       flush_out
);

  trap_state_t state_reg, state_next;
  logic [3:0]  cause_reg, cause_next;
  logic        i_or_e_reg, i_or_e_next;

  logic        enc_exc;
  logic        enc_irq;
  logic [3:0]  enc_cause;
  logic        enc_i_or_e;

  msrv32_trap_priority_encoder u_priority (
    .illegal_instr_in    (illegal_instr_in),
    .misaligned_instr_in (misaligned_instr_in),
    .misaligned_load_in  (misaligned_load_in),
    .misaligned_store_in (misaligned_store_in),
    .ecall_in            (ecall_in),
    .ebreak_in           (ebreak_in),
    .mie_in              (mie_in),
    .meie_in             (meie_in),
    .mtie_in             (mtie_in),
    .msie_in             (msie_in),
    .meip_in             (meip_in),
    .mtip_in             (mtip_in),
    .msip_in             (msip_in),
    .exc                 (enc_exc),
    .irq                 (enc_irq),
    .cause               (enc_cause),
    .i_or_e              (enc_i_or_e)
  );

  always_ff @(posedge clock) begin
    if (!rst_in) begin
      state_reg  <= STATE_RESET;
      cause_reg  <= 4'd0;
      i_or_e_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cause_reg  <= cause_next;
      i_or_e_reg <= i_or_e_next;
    end
  end

  assign cause_out  = cause_reg;
  assign i_or_e_out = i_or_e_reg;

  always_comb begin
    state_next               = state_reg;
    cause_next               = cause_reg;
    i_or_e_next              = i_or_e_reg;
    pc_src_out               = PC_BOOT;
    flush_out                = 1'b0;
    set_cause_out            = 1'b0;
    set_epc_out              = 1'b0;
    mie_clear_out            = 1'b0;
    mie_set_out              = 1'b0;
    misaligned_exception_out = 1'b0;
    instret_inc_out          = 1'b0;
    case (state_reg)
      STATE_RESET: begin
        flush_out  = 1'b1;
        state_next = STATE_OPERATING;
      end
      STATE_OPERATING: begin
        pc_src_out      = PC_NEXT;
        instret_inc_out = ~(enc_exc | enc_irq);
        if (enc_exc | enc_irq) begin
          state_next  = STATE_TRAP_TAKEN;
          cause_next  = enc_cause;
          i_or_e_next = enc_i_or_e;
        end else if (mret_in) begin
          state_next = STATE_TRAP_RETURN;
        end
      end
      STATE_TRAP_TAKEN: begin
        set_cause_out   = 1'b1;
        set_epc_out     = 1'b1;
        mie_clear_out   = 1'b1;
        pc_src_out      = PC_TRAP;
        flush_out       = 1'b1;
        // mtval gets the faulting address only for the three misalignment exceptions
        misaligned_exception_out = ~i_or_e_reg &
          ((cause_reg == CAUSE_INSTR_MISALIGN) || (cause_reg == CAUSE_LOAD_MISALIGN) ||
           (cause_reg == CAUSE_STORE_MISALIGN));
        state_next      = STATE_OPERATING;
      end
      STATE_TRAP_RETURN: begin
        mie_set_out = 1'b1;
        pc_src_out  = PC_EPC;
        flush_out   = 1'b1;
        state_next  = STATE_OPERATING;
      end
      default: state_next = STATE_RESET;
    endcase
  end

endmodule
